// File: rtl/alu_result_demux_pkg.sv
// Shared ALU definitions: result/flag widths, NZVC bit positions, result-select
// encoding, and the channel identifiers used by the result demultiplexer.
package alu_result_demux_pkg;

    localparam int DW = 8;
    localparam int FW = 4;

    // Flag vector order is {N, Z, V, C}
    localparam int NZVC_N = 3;
    localparam int NZVC_Z = 2;
    localparam int NZVC_V = 1;
    localparam int NZVC_C = 0;

    localparam int RES_SEL_W = 2;

    typedef enum logic [RES_SEL_W-1:0] {
        RES_ARITH = 2'd0,
        RES_LOGIC = 2'd1,
        RES_SHIFT = 2'd2,
        RES_PASS  = 2'd3
    } res_sel_e;

    localparam int CNT_W = 8;

    typedef enum logic {
        CH0 = 1'b0,
        CH1 = 1'b1
    } chan_e;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/alu_result_demux_sync_fifo.sv
// Synchronous FIFO with registered storage; the head entry is read straight
// from the storage array, so it only changes on a clock edge.
module sync_fifo
    import alu_result_demux_pkg::*;
#(
    parameter int WIDTH = 12,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = ptr_width(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    occ;
    logic             do_push;
    logic             do_pop;

    assign full    = (occ == LW'(DEPTH));
    assign empty   = (occ == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // DEPTH is a power of two, so pointer wrap is the natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: rtl/alu_result_demux.sv
// Routes ALU results with their NZVC flags to one of two buffered channels and
// counts the results delivered on each channel.
module alu_result_demux #(
    parameter int DW    = alu_result_demux_pkg::DW,
    parameter int FW    = alu_result_demux_pkg::FW,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic [FW-1:0] in_nzvc,
    input  logic          sel,
    output logic          out0_valid,
    input  logic          out0_ready,
    output logic [DW-1:0] out0_data,
    output logic [FW-1:0] out0_nzvc,
    output logic [alu_result_demux_pkg::CNT_W-1:0] out0_cnt,
    output logic          out1_valid,
    input  logic          out1_ready,
    output logic [DW-1:0] out1_data,
    output logic [FW-1:0] out1_nzvc,
    output logic [alu_result_demux_pkg::CNT_W-1:0] out1_cnt
);

    import alu_result_demux_pkg::*;

    localparam int EW = DW + FW;

    chan_e         dest;
    logic [EW-1:0] entry;
    logic [EW-1:0] head0;
    logic [EW-1:0] head1;
    logic          full0;
    logic          full1;
    logic          empty0;
    logic          empty1;
    logic          push0;
    logic          push1;
    logic          pop0;
    logic          pop1;

    assign dest  = chan_e'(sel);
    assign entry = {in_data, in_nzvc};

    // Readiness looks only at the selected buffer's registered fullness, so a
    // same-cycle pop never opens a full buffer.
    assign in_ready = (dest == CH1) ? !full1 : !full0;

    assign push0 = in_valid && in_ready && (dest == CH0);
    assign push1 = in_valid && in_ready && (dest == CH1);
    assign pop0  = out0_valid && out0_ready;
    assign pop1  = out1_valid && out1_ready;

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo0 (
        .clk       (clk),
        .rst       (rst),
        .push      (push0),
        .push_data (entry),
        .pop       (pop0),
        .full      (full0),
        .empty     (empty0),
        .head      (head0)
    );

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo1 (
        .clk       (clk),
        .rst       (rst),
        .push      (push1),
        .push_data (entry),
        .pop       (pop1),
        .full      (full1),
        .empty     (empty1),
        .head      (head1)
    );

    assign out0_valid = !empty0;
    assign out0_data  = head0[EW-1:FW];
    assign out0_nzvc  = head0[FW-1:0];
    assign out1_valid = !empty1;
    assign out1_data  = head1[EW-1:FW];
    assign out1_nzvc  = head1[FW-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            out0_cnt <= '0;
            out1_cnt <= '0;
        end else begin
            if (pop0) begin
                out0_cnt <= out0_cnt + 1'b1;
            end
            if (pop1) begin
                out1_cnt <= out1_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_result_demux.sv
// Bench for alu_result_demux: directed vector table, a count-wrap sequence and
// randomized traffic checked against a queue-based model.
module tb_alu_result_demux;

    localparam int DEPTH = 2;
    localparam int NROWS = 19;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [3:0] in_nzvc;
    logic       sel;
    logic       out0_valid;
    logic       out0_ready;
    logic [7:0] out0_data;
    logic [3:0] out0_nzvc;
    logic [7:0] out0_cnt;
    logic       out1_valid;
    logic       out1_ready;
    logic [7:0] out1_data;
    logic [3:0] out1_nzvc;
    logic [7:0] out1_cnt;

    int tests = 0;
    int fails = 0;

    logic [11:0] q0[$];
    logic [11:0] q1[$];
    int          mcnt0;
    int          mcnt1;

    typedef struct {
        logic       rst;
        logic       sel;
        logic       v;
        logic [7:0] d;
        logic [3:0] n;
        logic       r0;
        logic       r1;
        logic       rdy;
        logic       v0;
        logic [7:0] d0;
        logic [3:0] n0;
        logic       v1;
        logic [7:0] d1;
        logic [3:0] n1;
        logic [7:0] c0;
        logic [7:0] c1;
    } vec_t;

    vec_t tbl [NROWS];

    alu_result_demux #(
        .DW    (8),
        .FW    (4),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_nzvc    (in_nzvc),
        .sel        (sel),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out0_nzvc  (out0_nzvc),
        .out0_cnt   (out0_cnt),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data),
        .out1_nzvc  (out1_nzvc),
        .out1_cnt   (out1_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference behaviour at one clock edge, from the current inputs.
    task automatic model_edge();
        bit p;
        bit p0;
        bit p1;
        int sz;
        if (rst) begin
            q0.delete();
            q1.delete();
            mcnt0 = 0;
            mcnt1 = 0;
            return;
        end
        sz = sel ? q1.size() : q0.size();
        p  = in_valid && (sz < DEPTH);
        p0 = out0_ready && (q0.size() > 0);
        p1 = out1_ready && (q1.size() > 0);
        if (p0) begin
            void'(q0.pop_front());
            mcnt0 = (mcnt0 + 1) % 256;
        end
        if (p1) begin
            void'(q1.pop_front());
            mcnt1 = (mcnt1 + 1) % 256;
        end
        if (p) begin
            if (sel) q1.push_back({in_data, in_nzvc});
            else     q0.push_back({in_data, in_nzvc});
        end
    endtask

    task automatic check_outputs(input string tag);
        chk($sformatf("%s out0_valid", tag), 32'(out0_valid), 32'(q0.size() > 0));
        if (q0.size() > 0) begin
            chk($sformatf("%s out0_data", tag), 32'(out0_data), 32'(q0[0][11:4]));
            chk($sformatf("%s out0_nzvc", tag), 32'(out0_nzvc), 32'(q0[0][3:0]));
        end
        chk($sformatf("%s out1_valid", tag), 32'(out1_valid), 32'(q1.size() > 0));
        if (q1.size() > 0) begin
            chk($sformatf("%s out1_data", tag), 32'(out1_data), 32'(q1[0][11:4]));
            chk($sformatf("%s out1_nzvc", tag), 32'(out1_nzvc), 32'(q1[0][3:0]));
        end
        chk($sformatf("%s out0_cnt", tag), 32'(out0_cnt), 32'(mcnt0));
        chk($sformatf("%s out1_cnt", tag), 32'(out1_cnt), 32'(mcnt1));
    endtask

    // Inputs must already be applied; checks readiness, clocks, checks outputs.
    task automatic model_cycle(input string tag);
        int sz;
        sz = sel ? q1.size() : q0.size();
        chk($sformatf("%s in_ready", tag), 32'(in_ready), 32'(sz < DEPTH));
        model_edge();
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    initial begin
        //           rst   sel   v     d      n     r0    r1  | rdy  v0    d0     n0    v1    d1     n1    c0     c1
        tbl[0]  = '{1'b0, 1'b0, 1'b1, 8'hAA, 4'hC, 1'b0, 1'b0, 1'b1, 1'b1, 8'hAA, 4'hC, 1'b0, 8'h00, 4'h0, 8'd0, 8'd0};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 8'h55, 4'h3, 1'b0, 1'b0, 1'b1, 1'b1, 8'hAA, 4'hC, 1'b1, 8'h55, 4'h3, 8'd0, 8'd0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 8'h00, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1, 8'hAA, 4'hC, 1'b0, 8'h00, 4'h0, 8'd0, 8'd1};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 4'h0, 1'b0, 8'h00, 4'h0, 8'd0, 8'd0};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 8'hAA, 4'hC, 1'b0, 1'b0, 1'b1, 1'b1, 8'hAA, 4'hC, 1'b0, 8'h00, 4'h0, 8'd0, 8'd0};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 8'h11, 4'h1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hAA, 4'hC, 1'b0, 8'h00, 4'h0, 8'd0, 8'd0};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 8'h22, 4'h2, 1'b0, 1'b0, 1'b0, 1'b1, 8'hAA, 4'hC, 1'b0, 8'h00, 4'h0, 8'd0, 8'd0};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 8'h22, 4'h2, 1'b1, 1'b0, 1'b0, 1'b1, 8'h11, 4'h1, 1'b0, 8'h00, 4'h0, 8'd1, 8'd0};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 8'h22, 4'h2, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 4'h1, 1'b0, 8'h00, 4'h0, 8'd1, 8'd0};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 8'h33, 4'h5, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 4'h1, 1'b1, 8'h33, 4'h5, 8'd1, 8'd0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h22, 4'h2, 1'b0, 8'h00, 4'h0, 8'd2, 8'd1};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 8'h44, 4'h6, 1'b1, 1'b0, 1'b1, 1'b1, 8'h44, 4'h6, 1'b0, 8'h00, 4'h0, 8'd3, 8'd1};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 4'h0, 1'b0, 8'h00, 4'h0, 8'd4, 8'd1};
        tbl[13] = '{1'b0, 1'b0, 1'b1, 8'h01, 4'h1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 4'h1, 1'b0, 8'h00, 4'h0, 8'd4, 8'd1};
        tbl[14] = '{1'b0, 1'b0, 1'b1, 8'h02, 4'h2, 1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 4'h1, 1'b0, 8'h00, 4'h0, 8'd4, 8'd1};
        tbl[15] = '{1'b0, 1'b1, 1'b1, 8'h03, 4'h3, 1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 4'h1, 1'b1, 8'h03, 4'h3, 8'd4, 8'd1};
        tbl[16] = '{1'b0, 1'b1, 1'b1, 8'h04, 4'h4, 1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 4'h1, 1'b1, 8'h03, 4'h3, 8'd4, 8'd1};
        tbl[17] = '{1'b1, 1'b1, 1'b1, 8'h05, 4'h5, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 8'h00, 4'h0, 8'd0, 8'd0};
        tbl[18] = '{1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 4'h0, 1'b0, 8'h00, 4'h0, 8'd0, 8'd0};

        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        in_nzvc    = 4'h0;
        sel        = 1'b0;
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset out0_valid", 32'(out0_valid), 32'd0);
        chk("reset out1_valid", 32'(out1_valid), 32'd0);
        chk("reset out0_cnt", 32'(out0_cnt), 32'd0);
        chk("reset out1_cnt", 32'(out1_cnt), 32'd0);
        chk("reset out0_data", 32'(out0_data), 32'd0);
        chk("reset out1_nzvc", 32'(out1_nzvc), 32'd0);
        rst = 1'b0;
        #1;
        chk("post-reset in_ready sel0", 32'(in_ready), 32'd1);
        sel = 1'b1;
        #1;
        chk("post-reset in_ready sel1", 32'(in_ready), 32'd1);

        for (int i = 0; i < NROWS; i++) begin
            rst        = tbl[i].rst;
            sel        = tbl[i].sel;
            in_valid   = tbl[i].v;
            in_data    = tbl[i].d;
            in_nzvc    = tbl[i].n;
            out0_ready = tbl[i].r0;
            out1_ready = tbl[i].r1;
            #1;
            chk($sformatf("row%0d in_ready", i), 32'(in_ready), 32'(tbl[i].rdy));
            @(posedge clk);
            #1;
            chk($sformatf("row%0d out0_valid", i), 32'(out0_valid), 32'(tbl[i].v0));
            chk($sformatf("row%0d out1_valid", i), 32'(out1_valid), 32'(tbl[i].v1));
            if (tbl[i].v0 || tbl[i].rst) begin
                chk($sformatf("row%0d out0_data", i), 32'(out0_data), 32'(tbl[i].d0));
                chk($sformatf("row%0d out0_nzvc", i), 32'(out0_nzvc), 32'(tbl[i].n0));
            end
            if (tbl[i].v1 || tbl[i].rst) begin
                chk($sformatf("row%0d out1_data", i), 32'(out1_data), 32'(tbl[i].d1));
                chk($sformatf("row%0d out1_nzvc", i), 32'(out1_nzvc), 32'(tbl[i].n1));
            end
            chk($sformatf("row%0d out0_cnt", i), 32'(out0_cnt), 32'(tbl[i].c0));
            chk($sformatf("row%0d out1_cnt", i), 32'(out1_cnt), 32'(tbl[i].c1));
        end

        // Table leaves both channels empty with zero counts.
        q0.delete();
        q1.delete();
        mcnt0 = 0;
        mcnt1 = 0;

        // Streaming push+pop on channel 0 until its count wraps.
        rst        = 1'b0;
        sel        = 1'b0;
        in_valid   = 1'b1;
        out0_ready = 1'b1;
        out1_ready = 1'b0;
        for (int k = 0; k <= 256; k++) begin
            in_data = 8'($urandom);
            in_nzvc = 4'($urandom);
            #1;
            model_cycle($sformatf("wrap%0d", k));
            if (k == 255) chk("wrap out0_cnt at 255", 32'(out0_cnt), 32'd255);
            if (k == 256) chk("wrap out0_cnt to 0", 32'(out0_cnt), 32'd0);
        end

        for (int k = 0; k < 3000; k++) begin
            rst        = ($urandom_range(0, 99) == 0);
            sel        = 1'($urandom);
            in_valid   = ($urandom_range(0, 3) != 0);
            in_data    = 8'($urandom);
            in_nzvc    = 4'($urandom);
            out0_ready = ($urandom_range(0, 2) == 0);
            out1_ready = ($urandom_range(0, 2) != 0);
            #1;
            model_cycle($sformatf("rand%0d", k));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
